io_bus_arbiter: RTL and testbench

Shares the 16-bit external I/O peripheral bus between two masters: the Nios II external-bus bridge (port A) and a hardware requester such as the package-sensor scanner (port B). It grants the bus round-robin, issues one transaction at a time to the peripheral side, and returns data and acknowledge to the granted master. A watchdog aborts transactions the peripheral never acknowledges and raises a sticky interrupt toward the Nios interrupt input.

---
 rtl/io_bus_arbiter_pkg.sv | 22 ++
 rtl/io_bus_arbiter_rr_arb2.sv | 33 +++
 rtl/io_bus_arbiter.sv | 164 ++++++++++++++++
 tb/tb_io_bus_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_arbiter_pkg.sv
// Shared types and defaults for the two-master I/O bus arbiter.
package io_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP,
      ST_RELEASE
   } state_e;

   localparam int unsigned TIMEOUT_CYCLES_DEF = 255;
   localparam logic [15:0] ERR_DATA_DEF       = 16'hFFFF;

   typedef struct packed {
      logic        rw;
      logic [15:0] address;
      logic [1:0]  byte_enable;
      logic [15:0] write_data;
   } req_t;

endpackage

// File: rtl/io_bus_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; on a tie the master not granted last wins.
module rr_arb2 (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic req_a_i,
   input  logic req_b_i,
   output logic gnt_a_o,
   output logic gnt_b_o
);

   logic last_b_q, last_b_d;

   // Grant decision and last-grant update, the latter only when a grant is taken
   always_comb begin
      gnt_b_o  = req_b_i && (!req_a_i || !last_b_q);
      gnt_a_o  = req_a_i && !gnt_b_o;
      last_b_d = last_b_q;
      if (en_i && (req_a_i || req_b_i)) begin
         last_b_d = gnt_b_o;
      end
   end

   // Last-grant register; resets to B so A wins the first tie
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_b_q <= 1'b1;
      end else begin
         last_b_q <= last_b_d;
      end
   end

endmodule

// File: rtl/io_bus_arbiter.sv
// Shares the 16-bit peripheral bus between masters A and B, one transaction
// at a time, with a watchdog that aborts unacknowledged transactions.
module io_bus_arbiter
   import io_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter logic [15:0] ERR_DATA       = ERR_DATA_DEF
) (
   input  logic        clk_clk,
   input  logic        reset_reset,
   input  logic        a_bus_enable,
   input  logic        a_rw,
   input  logic [15:0] a_address,
   input  logic [1:0]  a_byte_enable,
   input  logic [15:0] a_write_data,
   output logic [15:0] a_read_data,
   output logic        a_acknowledge,
   input  logic        b_bus_enable,
   input  logic        b_rw,
   input  logic [15:0] b_address,
   input  logic [1:0]  b_byte_enable,
   input  logic [15:0] b_write_data,
   output logic [15:0] b_read_data,
   output logic        b_acknowledge,
   output logic        p_bus_enable,
   output logic        p_rw,
   output logic [15:0] p_address,
   output logic [1:0]  p_byte_enable,
   output logic [15:0] p_write_data,
   input  logic [15:0] p_read_data,
   input  logic        p_acknowledge,
   output logic        irq,
   input  logic        irq_clear,
   output logic        err_src
);

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_e      state_q, state_d;
   req_t        req_q, req_d, preq_q, preq_d, a_req, b_req;
   logic        gnt_b_q, gnt_b_d;
   logic [15:0] cnt_q, cnt_d;
   logic        pbe_q, pbe_d;
   logic [15:0] a_rd_q, a_rd_d, b_rd_q, b_rd_d;
   logic        a_ack_q, a_ack_d, b_ack_q, b_ack_d;
   logic        irq_q, irq_d, err_q, err_d;
   logic        arb_gnt_a, arb_gnt_b, timeout;

   assign a_req = '{a_rw, a_address, a_byte_enable, a_write_data};
   assign b_req = '{b_rw, b_address, b_byte_enable, b_write_data};

   rr_arb2 u_arb (
      .clk_i   (clk_clk),
      .rst_i   (reset_reset),
      .en_i    (state_q == ST_IDLE),
      .req_a_i (a_bus_enable),
      .req_b_i (b_bus_enable),
      .gnt_a_o (arb_gnt_a),
      .gnt_b_o (arb_gnt_b)
   );

   // Next-state and registered-output logic for the transaction sequencer
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      preq_d  = preq_q;
      gnt_b_d = gnt_b_q;
      cnt_d   = cnt_q;
      pbe_d   = pbe_q;
      a_rd_d  = a_rd_q;
      b_rd_d  = b_rd_q;
      a_ack_d = 1'b0;
      b_ack_d = 1'b0;
      irq_d   = irq_q;
      err_d   = err_q;
      timeout = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (arb_gnt_a || arb_gnt_b) begin
               gnt_b_d = arb_gnt_b;
               req_d   = arb_gnt_b ? b_req : a_req;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            preq_d  = req_q;
            pbe_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // A peripheral acknowledge takes priority over an expiring watchdog
            if (p_acknowledge || cnt_q >= TO_LAST) begin
               timeout = !p_acknowledge;
               if (gnt_b_q) b_rd_d = p_acknowledge ? p_read_data : ERR_DATA;
               else         a_rd_d = p_acknowledge ? p_read_data : ERR_DATA;
               pbe_d   = 1'b0;
               state_d = ST_RESP;
            end else if (cnt_q != 16'hFFFF) begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_RESP: begin
            a_ack_d = !gnt_b_q;
            b_ack_d = gnt_b_q;
            state_d = ST_RELEASE;
         end
         ST_RELEASE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
      // A new timeout outranks a simultaneous clear
      if (timeout) begin
         irq_d = 1'b1;
         err_d = gnt_b_q;
      end else if (irq_clear) begin
         irq_d = 1'b0;
         err_d = 1'b0;
      end
   end

   // State and output registers; reset aborts any transaction without acknowledge
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q <= ST_IDLE;
         req_q   <= '0;
         preq_q  <= '0;
         gnt_b_q <= 1'b0;
         cnt_q   <= '0;
         pbe_q   <= 1'b0;
         a_rd_q  <= '0;
         b_rd_q  <= '0;
         a_ack_q <= 1'b0;
         b_ack_q <= 1'b0;
         irq_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         preq_q  <= preq_d;
         gnt_b_q <= gnt_b_d;
         cnt_q   <= cnt_d;
         pbe_q   <= pbe_d;
         a_rd_q  <= a_rd_d;
         b_rd_q  <= b_rd_d;
         a_ack_q <= a_ack_d;
         b_ack_q <= b_ack_d;
         irq_q   <= irq_d;
         err_q   <= err_d;
      end
   end

   assign p_bus_enable  = pbe_q;
   assign p_rw          = preq_q.rw;
   assign p_address     = preq_q.address;
   assign p_byte_enable = preq_q.byte_enable;
   assign p_write_data  = preq_q.write_data;
   assign a_read_data   = a_rd_q;
   assign b_read_data   = b_rd_q;
   assign a_acknowledge = a_ack_q;
   assign b_acknowledge = b_ack_q;
   assign irq           = irq_q;
   assign err_src       = err_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter with an 8-cycle watchdog.
module tb_io_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        a_be = 1'b0, a_rw = 1'b0, b_be = 1'b0, b_rw = 1'b0;
   logic [15:0] a_addr = '0, a_wd = '0, b_addr = '0, b_wd = '0;
   logic [1:0]  a_bye = 2'b11, b_bye = 2'b11;
   logic [15:0] a_rd, b_rd, p_addr, p_wd, p_rdata = '0;
   logic        a_ack, b_ack, p_be, p_rw, p_ack = 1'b0, irq, irq_clr = 1'b0, err_src;
   logic [1:0]  p_bye;

   int nvec = 0;
   int nbad = 0;

   always #5 clk = ~clk;

   io_bus_arbiter #(.TIMEOUT_CYCLES(8), .ERR_DATA(16'hFFFF)) dut (
      .clk_clk(clk), .reset_reset(rst),
      .a_bus_enable(a_be), .a_rw(a_rw), .a_address(a_addr), .a_byte_enable(a_bye),
      .a_write_data(a_wd), .a_read_data(a_rd), .a_acknowledge(a_ack),
      .b_bus_enable(b_be), .b_rw(b_rw), .b_address(b_addr), .b_byte_enable(b_bye),
      .b_write_data(b_wd), .b_read_data(b_rd), .b_acknowledge(b_ack),
      .p_bus_enable(p_be), .p_rw(p_rw), .p_address(p_addr), .p_byte_enable(p_bye),
      .p_write_data(p_wd), .p_read_data(p_rdata), .p_acknowledge(p_ack),
      .irq(irq), .irq_clear(irq_clr), .err_src(err_src)
   );

   typedef struct {
      logic        rst;
      logic        a_be;
      logic        a_rw;
      logic [15:0] a_addr;
      logic        p_ack;
      logic [15:0] p_rdata;
      logic        exp_pbe;
      logic [15:0] exp_addr;
      logic        exp_aack;
      logic        exp_back;
      logic [15:0] exp_ard;
      logic        exp_irq;
   } vec_t;

   vec_t tbl [10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic do_reset();
      a_be = 1'b0; b_be = 1'b0; p_ack = 1'b0; irq_clr = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_pbe();
      for (int i = 0; i < 20 && p_be !== 1'b1; i++) tick();
      check("pbe_rise", 64'(p_be), 64'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      // Reset, then a single A read acknowledged in the 4th WAIT cycle
      tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 1'b0};
      tbl[4] = '{1'b0, 1'b1, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 1'b0};
      tbl[6] = '{1'b0, 1'b1, 1'b1, 16'h0010, 1'b1, 16'h1234, 1'b0, 16'h0010, 1'b0, 1'b0, 16'h1234, 1'b0};
      tbl[7] = '{1'b0, 1'b1, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0010, 1'b1, 1'b0, 16'h1234, 1'b0};
      tbl[8] = '{1'b0, 1'b1, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0010, 1'b0, 1'b0, 16'h1234, 1'b0};
      tbl[9] = '{1'b0, 1'b0, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0010, 1'b0, 1'b0, 16'h1234, 1'b0};

      for (int i = 0; i < 10; i++) begin
         rst = tbl[i].rst; a_be = tbl[i].a_be; a_rw = tbl[i].a_rw; a_addr = tbl[i].a_addr;
         p_ack = tbl[i].p_ack; p_rdata = tbl[i].p_rdata;
         tick();
         check($sformatf("vec%0d {pbe,addr,aack,back,ard,irq}", i),
               64'({p_be, p_addr, a_ack, b_ack, a_rd, irq}),
               64'({tbl[i].exp_pbe, tbl[i].exp_addr, tbl[i].exp_aack, tbl[i].exp_back,
                    tbl[i].exp_ard, tbl[i].exp_irq}));
      end
      rst = 1'b0; p_ack = 1'b0;

      // Contention with both requests held: A, B, A
      do_reset();
      a_rw = 1'b0; a_addr = 16'h0A00; a_wd = 16'hAAAA;
      b_rw = 1'b0; b_addr = 16'h0B00; b_wd = 16'hBBBB;
      a_be = 1'b1; b_be = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_pbe();
         check($sformatf("rr%0d_wdata", k), 64'(p_wd), 64'((k == 1) ? 16'hBBBB : 16'hAAAA));
         p_ack = 1'b1; p_rdata = 16'h0000;
         tick();
         p_ack = 1'b0;
         tick();
         check($sformatf("rr%0d_acks", k), 64'({a_ack, b_ack}), 64'((k == 1) ? 2'b01 : 2'b10));
      end
      a_be = 1'b0; b_be = 1'b0;
      tick();

      // B read, peripheral silent: watchdog abort after 8 cycles
      do_reset();
      b_rw = 1'b1; b_addr = 16'h0B10; b_be = 1'b1;
      wait_pbe();
      begin
         int hi = 0;
         while (p_be === 1'b1 && hi < 100) begin
            hi++;
            tick();
         end
         check("to_pbe_cycles", 64'(hi), 64'(8));
      end
      check("to_irq_err", 64'({irq, err_src}), 64'(2'b11));
      tick();
      check("to_back_rd", 64'({a_ack, b_ack, b_rd}), 64'({2'b01, 16'hFFFF}));
      b_be = 1'b0;
      tick();
      irq_clr = 1'b1;
      tick();
      irq_clr = 1'b0;
      check("irq_clear", 64'({irq, err_src}), 64'(2'b00));

      // Acknowledge on the final watchdog cycle wins
      do_reset();
      a_rw = 1'b1; a_addr = 16'h0040; a_be = 1'b1;
      wait_pbe();
      for (int i = 0; i < 7; i++) tick();
      p_ack = 1'b1; p_rdata = 16'h5A5A;
      tick();
      p_ack = 1'b0;
      check("edge_pbe_irq", 64'({p_be, irq}), 64'(2'b00));
      tick();
      check("edge_ack_rd", 64'({a_ack, a_rd, irq}), 64'({1'b1, 16'h5A5A, 1'b0}));
      a_be = 1'b0;
      tick();

      // Reset while in WAIT aborts silently; a fresh request then completes
      a_rw = 1'b0; a_addr = 16'h0050; a_wd = 16'h7777; a_be = 1'b1;
      wait_pbe();
      tick();
      rst = 1'b1; a_be = 1'b0;
      tick();
      check("rst_mid_outputs",
            64'({p_be, p_rw, p_addr, p_bye, a_ack, b_ack, irq, err_src}), 64'(0));
      rst = 1'b0;
      tick();
      check("rst_mid_noack", 64'({a_ack, b_ack, a_rd}), 64'(0));
      a_rw = 1'b1; a_addr = 16'h0020; a_be = 1'b1;
      wait_pbe();
      check("fresh_addr", 64'({p_rw, p_addr}), 64'({1'b1, 16'h0020}));
      p_ack = 1'b1; p_rdata = 16'h0F0F;
      tick();
      p_ack = 1'b0;
      tick();
      check("fresh_ack", 64'({a_ack, a_rd}), 64'({1'b1, 16'h0F0F}));

      // a_bus_enable still high during RELEASE must not produce a second grant
      tick();
      a_be = 1'b0;
      begin
         int seen = 0;
         for (int i = 0; i < 5; i++) begin
            tick();
            if (p_be === 1'b1) seen++;
         end
         check("stale_no_regrant", 64'(seen), 64'(0));
      end
      a_addr = 16'h0030; a_be = 1'b1;
      wait_pbe();
      check("new_after_low", 64'(p_addr), 64'(16'h0030));
      p_ack = 1'b1; p_rdata = 16'h3333;
      tick();
      p_ack = 1'b0;
      tick();
      check("new_ack", 64'({a_ack, a_rd}), 64'({1'b1, 16'h3333}));
      a_be = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
